rr_arbiter_8: RTL and testbench

Round-robin arbiter that shares one resource among 8 requesters. It issues a registered one-hot grant plus the equivalent 3-bit binary index, so the grant can drive a select-encoded datapath directly. The granted requester owns the resource until it drops its request or exceeds a configurable hold limit. It sits between the requesters and the shared resource's select/enable inputs.

---
 rtl/rr_arb_pkg.sv | 20 ++
 rtl/onehot_enc8.sv | 19 +
 rtl/rr_arbiter_8.sv | 146 ++++++++++++++
 tb/tb_rr_arbiter_8.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared constants, types and helpers for the 8-way round-robin arbiter.
package rr_arb_pkg;

  localparam int N_REQ  = 8;
  localparam int IDX_W  = 3;
  localparam int HCNT_W = 8;

  // Arbiter ownership state: either nobody holds the resource or one owner does.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  // Distance from the previous owner to the first candidate in search order.
  // Returns 1..8 so that a shift by N_REQ means "no rotation at all".
  function automatic logic [IDX_W:0] searchShift(input logic [IDX_W-1:0] last);
    return {1'b0, last} + (IDX_W+1)'(1);
  endfunction

endpackage

// File: rtl/onehot_enc8.sv
// One-hot to binary encoder for an 8-bit grant vector; all-zero input gives 0.
module onehot_enc8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] onehot_i,
  output logic [IDX_W-1:0] idx_o
);

  // OR together the indices of all set bits; for a one-hot input this is the index.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (onehot_i[i]) begin
        idx_o = idx_o | IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant,
// its binary index and a valid flag. The owner keeps the resource until it
// drops its request or, when others are waiting, until its hold limit runs out.
module rr_arbiter_8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  // A zero MAX_HOLD disables the hold limit entirely.
  localparam logic             HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_t        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]  gntIdx_q, gntIdx_d;
  logic              gntValid_q, gntValid_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;

  logic [N_REQ-1:0]  otherReq;
  logic [N_REQ-1:0]  candGnt;
  logic              ownReq;
  logic              holdExpired;

  // Rotate right by s (0..8) using a doubled vector so the wrap is free.
  function automatic logic [N_REQ-1:0] rotRight(input logic [N_REQ-1:0] v,
                                                input logic [IDX_W:0]   s);
    logic [2*N_REQ-1:0] dbl;
    dbl = {v, v} >> s;
    return dbl[N_REQ-1:0];
  endfunction

  // Rotate left by s (0..8); the upper half of the doubled vector is the result.
  function automatic logic [N_REQ-1:0] rotLeft(input logic [N_REQ-1:0] v,
                                               input logic [IDX_W:0]   s);
    logic [2*N_REQ-1:0] dbl;
    dbl = {v, v} << s;
    return dbl[2*N_REQ-1:N_REQ];
  endfunction

  // Requests other than the current owner; in IDLE gnt_q is zero so this is all of req.
  assign otherReq    = req & ~gnt_q;
  assign ownReq      = |(req & gnt_q);
  assign holdExpired = HOLD_EN && (hcnt_q == HOLD_LAST);

  // Rotating priority pick: align last+1 to bit 0, isolate the lowest set bit, align back.
  always_comb begin
    logic [IDX_W:0]   shift;
    logic [N_REQ-1:0] rotReq;
    logic [N_REQ-1:0] rotPick;
    shift   = searchShift(last_q);
    rotReq  = rotRight(otherReq, shift);
    rotPick = rotReq & (~rotReq + N_REQ'(1));
    candGnt = rotLeft(rotPick, shift);
  end

  // Next-state logic: grant from idle, hand off on release or hold expiry, count hold cycles.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    hcnt_d  = hcnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          gnt_d   = candGnt;
          state_d = ARB_OWN;
          hcnt_d  = '0;
        end
      end
      ARB_OWN: begin
        if (!ownReq) begin
          // Release wins over a simultaneous expiry.
          hcnt_d = '0;
          if (|otherReq) begin
            gnt_d = candGnt;
          end else begin
            gnt_d   = '0;
            state_d = ARB_IDLE;
          end
        end else if (holdExpired) begin
          // Expiry with nobody waiting just restarts the owner's count.
          hcnt_d = '0;
          if (|otherReq) begin
            gnt_d = candGnt;
          end
        end else if (hcnt_q != '1) begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        hcnt_d  = '0;
      end
    endcase
  end

  onehot_enc8 u_enc (
    .onehot_i (gnt_d),
    .idx_o    (gntIdx_d)
  );

  assign gntValid_d = |gnt_d;
  assign last_d     = gntValid_d ? gntIdx_d : last_q;

  // State and output registers; reset leaves requester 0 at top priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      gntIdx_q   <= '0;
      gntValid_q <= 1'b0;
      last_q     <= IDX_W'(N_REQ - 1);
      hcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gntIdx_q   <= gntIdx_d;
      gntValid_q <= gntValid_d;
      last_q     <= last_d;
      hcnt_q     <= hcnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gntIdx_q;
  assign gnt_valid = gntValid_q;

  // The grant never names more than one requester.
  assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));

  // Valid flag and grant vector always agree.
  assert property (@(posedge clk) disable iff (rst) (gntValid_q == (|gnt_q)));

  // An idle arbiter reports index 0.
  assert property (@(posedge clk) disable iff (rst) ((|gnt_q) || (gntIdx_q == '0)));

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 using three instances with different hold limits.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst;
  logic [7:0] req4, req1, req2;
  logic [7:0] gnt4, gnt1, gnt2;
  logic [2:0] idx4, idx1, idx2;
  logic       val4, val1, val2;

  int checks;
  int failures;

  rr_arbiter_8 #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4), .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(val4)
  );

  rr_arbiter_8 #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(val1)
  );

  rr_arbiter_8 #(.MAX_HOLD(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .gnt(gnt2), .gnt_idx(idx2), .gnt_valid(val2)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive the request vectors of all three instances.
  task automatic applyStimulus(input logic [7:0] r4, input logic [7:0] r1, input logic [7:0] r2);
    req4 = r4;
    req1 = r1;
    req2 = r2;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare one instance's outputs against the expected grant, index and valid.
  task automatic checkOutput(input string tag,
                             input logic [7:0] g, input logic [2:0] gi, input logic gv,
                             input logic [7:0] eg, input logic [2:0] ei, input logic ev);
    checks++;
    assert (g === eg) else begin
      failures++;
      $error("[TB] FAIL %s gnt got=%h exp=%h", tag, g, eg);
    end
    checks++;
    assert (gi === ei) else begin
      failures++;
      $error("[TB] FAIL %s gnt_idx got=%0d exp=%0d", tag, gi, ei);
    end
    checks++;
    assert (gv === ev) else begin
      failures++;
      $error("[TB] FAIL %s gnt_valid got=%b exp=%b", tag, gv, ev);
    end
  endtask

  // Directed sequence of steps.
  initial begin
    logic [7:0] expG;
    logic [2:0] expI;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(8'h00, 8'h00, 8'h00);

    step();
    step();
    checkOutput("reset_u4", gnt4, idx4, val4, 8'h00, 3'd0, 1'b0);
    checkOutput("reset_u1", gnt1, idx1, val1, 8'h00, 3'd0, 1'b0);
    checkOutput("reset_u2", gnt2, idx2, val2, 8'h00, 3'd0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("idle", gnt4, idx4, val4, 8'h00, 3'd0, 1'b0);
    end

    // Release handoff: owner 2, then 4 takes over with no gap.
    applyStimulus(8'b0001_0100, 8'h00, 8'h00);
    step();
    checkOutput("handoff_first", gnt4, idx4, val4, 8'h04, 3'd2, 1'b1);
    applyStimulus(8'h10, 8'h00, 8'h00);
    step();
    checkOutput("handoff_next", gnt4, idx4, val4, 8'h10, 3'd4, 1'b1);
    applyStimulus(8'h00, 8'h00, 8'h00);
    step();
    checkOutput("handoff_idle", gnt4, idx4, val4, 8'h00, 3'd0, 1'b0);

    // Hold limit 4: requester 3 owns exactly 4 cycles once 5 competes.
    applyStimulus(8'h08, 8'h00, 8'h00);
    step();
    checkOutput("hold_c1", gnt4, idx4, val4, 8'h08, 3'd3, 1'b1);
    applyStimulus(8'h28, 8'h00, 8'h00);
    step();
    checkOutput("hold_c2", gnt4, idx4, val4, 8'h08, 3'd3, 1'b1);
    step();
    checkOutput("hold_c3", gnt4, idx4, val4, 8'h08, 3'd3, 1'b1);
    step();
    checkOutput("hold_c4", gnt4, idx4, val4, 8'h08, 3'd3, 1'b1);
    step();
    checkOutput("hold_pass", gnt4, idx4, val4, 8'h20, 3'd5, 1'b1);

    // Async reset between edges while 5 owns.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst", gnt4, idx4, val4, 8'h00, 3'd0, 1'b0);
    #1;
    rst = 1'b0;
    applyStimulus(8'h21, 8'h00, 8'h00);
    step();
    checkOutput("post_rst_prio", gnt4, idx4, val4, 8'h01, 3'd0, 1'b1);
    applyStimulus(8'h20, 8'h00, 8'h00);
    step();
    checkOutput("post_rst_next", gnt4, idx4, val4, 8'h20, 3'd5, 1'b1);
    applyStimulus(8'h00, 8'h00, 8'h00);
    step();
    checkOutput("post_rst_idle", gnt4, idx4, val4, 8'h00, 3'd0, 1'b0);

    // Lone owner keeps the grant across several expiries.
    applyStimulus(8'h08, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("lone_hold", gnt4, idx4, val4, 8'h08, 3'd3, 1'b1);
    end
    // Count restarted at each expiry: two more cycles, then handoff.
    applyStimulus(8'h28, 8'h00, 8'h00);
    step();
    checkOutput("restart_c1", gnt4, idx4, val4, 8'h08, 3'd3, 1'b1);
    step();
    checkOutput("restart_c2", gnt4, idx4, val4, 8'h08, 3'd3, 1'b1);
    step();
    checkOutput("restart_pass", gnt4, idx4, val4, 8'h20, 3'd5, 1'b1);
    applyStimulus(8'h00, 8'h00, 8'h00);
    step();
    checkOutput("restart_idle", gnt4, idx4, val4, 8'h00, 3'd0, 1'b0);

    // Fairness rotation with hold limit 1: 0..7 then wrap to 0.
    applyStimulus(8'h00, 8'hFF, 8'h00);
    for (int k = 0; k < 9; k++) begin
      step();
      expG = 8'h01 << (k % 8);
      expI = 3'(k % 8);
      checkOutput("rotation", gnt1, idx1, val1, expG, expI, 1'b1);
    end
    applyStimulus(8'h00, 8'h00, 8'h00);
    step();
    checkOutput("rotation_idle", gnt1, idx1, val1, 8'h00, 3'd0, 1'b0);

    // Hold limit 2: owner 6 releases on its expiry cycle with 1 pending.
    applyStimulus(8'h00, 8'h00, 8'h40);
    step();
    checkOutput("simul_c1", gnt2, idx2, val2, 8'h40, 3'd6, 1'b1);
    applyStimulus(8'h00, 8'h00, 8'h42);
    step();
    checkOutput("simul_c2", gnt2, idx2, val2, 8'h40, 3'd6, 1'b1);
    applyStimulus(8'h00, 8'h00, 8'h02);
    step();
    checkOutput("simul_release", gnt2, idx2, val2, 8'h02, 3'd1, 1'b1);
    step();
    checkOutput("simul_keep", gnt2, idx2, val2, 8'h02, 3'd1, 1'b1);
    applyStimulus(8'h00, 8'h00, 8'h00);
    step();
    checkOutput("simul_idle", gnt2, idx2, val2, 8'h00, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
